// File: rtl/video_timing_if.sv
// Raster timing bundle between video_timing (master) and the pixel renderer (slave).
// pause travels toward the generator; everything else travels toward the renderer.
interface video_timing_if;
   logic       pause;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       hsync;
   logic       vsync;
   logic       frame_start;
   logic       line_start;
   logic       step;

   modport master (
      input  pause,
      output x, y, de, hsync, vsync, frame_start, line_start, step
   );

   modport slave (
      output pause,
      input  x, y, de, hsync, vsync, frame_start, line_start, step
   );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: pixel coordinates, active-low syncs, data enable,
// frame/line start pulses and a slow step strobe every STEP_FRAMES frames.
// Optional VIDEO_TIMING_LOOKAHEAD_EN: x/y lead the strobes by one pixel so a
// renderer that registers r/g/b lines up with de and the syncs.
module video_timing #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned STEP_FRAMES = 30
) (
   input logic            clk,
   input logic            rst,
   video_timing_if.master vif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_ACT_L   = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_L   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] STEP_LAST = 10'(STEP_FRAMES - 1);

   // h_q/v_q: pixel currently described by the strobes. Held at the last pixel
   // of the frame during reset so the first pixel after reset is (0,0).
   logic [9:0] h_q, h_d, v_q, v_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic [9:0] fcnt_q, fcnt_d;
   logic       de_q, de_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       frame_start_q, frame_start_d;
   logic       line_start_q, line_start_d;
   logic       step_q, step_d;

   // Raster order: h wraps every line, v advances on the h wrap.
   function automatic logic [19:0] advance(input logic [9:0] h, input logic [9:0] v);
      logic [9:0] hn, vn;
      hn = h + 10'd1;
      vn = v;
      if (h == H_LAST) begin
         hn = '0;
         vn = (v == V_LAST) ? '0 : v + 10'd1;
      end
      return {vn, hn};
   endfunction

   // Next pixel, its strobes, and the frame counter update on its frame start.
   always_comb begin
      {v_d, h_d}    = advance(h_q, v_q);
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
      {y_d, x_d}    = advance(h_d, v_d);
`else
      x_d           = h_d;
      y_d           = v_d;
`endif
      de_d          = (h_d < H_ACT_L) && (v_d < V_ACT_L);
      hsync_d       = !((h_d >= HS_START) && (h_d < HS_END));
      vsync_d       = !((v_d >= VS_START) && (v_d < VS_END));
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
      fcnt_d        = fcnt_q;
      step_d        = 1'b0;
      if (frame_start_d && !vif.pause) begin
         if (fcnt_q == STEP_LAST) begin
            fcnt_d = '0;
            step_d = 1'b1;
         end else begin
            fcnt_d = fcnt_q + 10'd1;
         end
      end
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         x_q           <= '0;
         y_q           <= '0;
         fcnt_q        <= '0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         step_q        <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         x_q           <= x_d;
         y_q           <= y_d;
         fcnt_q        <= fcnt_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         step_q        <= step_d;
      end
   end

   assign vif.x           = x_q;
   assign vif.y           = y_q;
   assign vif.de          = de_q;
   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.frame_start = frame_start_q;
   assign vif.line_start  = line_start_q;
   assign vif.step        = step_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a shrunken raster (24x11, STEP_FRAMES=3) for frame and
// step behaviour, plus the full 800x525 raster for line-level timing.
module tb_video_timing;

   localparam int SHA = 16, SHFP = 2, SHS = 3, SHBP = 3;
   localparam int SVA = 6,  SVFP = 1, SVS = 2, SVBP = 2;
   localparam int S_STEP  = 3;
   localparam int S_FRAME = 264;
   localparam int F_STEP  = 30;
   localparam int F_FRAME = 420000;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       hsync;
      logic       vsync;
      logic       fs;
      logic       ls;
      logic       step;
   } vt_t;

   logic clk;
   logic rst;
   logic pause;
   bit   chk_en;
   bit   rand_en;
   int   n_pass;
   int   n_total;

   // Model state: pos = pixel index within the frame shown on the strobes (-1 in reset),
   // k = number of unpaused frame starts since reset.
   int   pos_s, k_s, pos_f, k_f;
   bit   stp_s, stp_f;

   video_timing_if vif_s ();
   video_timing_if vif_f ();

   assign vif_s.pause = pause;
   assign vif_f.pause = pause;

   video_timing #(
      .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
      .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP),
      .STEP_FRAMES(S_STEP)
   ) dut_s (
      .clk(clk),
      .rst(rst),
      .vif(vif_s)
   );

   video_timing #(
      .STEP_FRAMES(F_STEP)
   ) dut_f (
      .clk(clk),
      .rst(rst),
      .vif(vif_f)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Strobes for a pixel index purely from the porch/sync arithmetic.
   function automatic vt_t raster(input int pos, input int ha, hfp, hs, hbp, va, vfp, vs, vbp);
      int ht, vt, p, h, v;
      vt_t r;
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      p = pos % (ht * vt);
      h = p % ht;
      v = p / ht;
      r.x     = 10'(h);
      r.y     = 10'(v);
      r.de    = (h < ha) && (v < va);
      r.hsync = !((h >= ha + hfp) && (h < ha + hfp + hs));
      r.vsync = !((v >= va + vfp) && (v < va + vfp + vs));
      r.fs    = (p == 0);
      r.ls    = (h == 0);
      r.step  = 1'b0;
      return r;
   endfunction

   function automatic vt_t raster_sel(input bit full, input int pos);
      if (full) return raster(pos, 640, 16, 96, 48, 480, 10, 2, 33);
      return raster(pos, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP);
   endfunction

   function automatic vt_t expect_out(input bit full, input int pos, input bit stp);
      vt_t r;
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
      vt_t c;
`endif
      if (pos < 0) return '{x: 10'd0, y: 10'd0, de: 1'b0, hsync: 1'b1, vsync: 1'b1,
                            fs: 1'b0, ls: 1'b0, step: 1'b0};
      r = raster_sel(full, pos);
`ifdef VIDEO_TIMING_LOOKAHEAD_EN
      c = raster_sel(full, pos + 1);
      r.x = c.x;
      r.y = c.y;
`endif
      r.step = stp;
      return r;
   endfunction

   function automatic int next_pos(input int pos, input int frame);
      return (pos < 0) ? 0 : (pos + 1) % frame;
   endfunction

   // Reference model advance on each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         pos_s <= -1; k_s <= 0; stp_s <= 1'b0;
         pos_f <= -1; k_f <= 0; stp_f <= 1'b0;
      end else begin
         pos_s <= next_pos(pos_s, S_FRAME);
         pos_f <= next_pos(pos_f, F_FRAME);
         if (next_pos(pos_s, S_FRAME) == 0 && !pause) begin
            k_s   <= k_s + 1;
            stp_s <= ((k_s + 1) % S_STEP) == 0;
         end else begin
            stp_s <= 1'b0;
         end
         if (next_pos(pos_f, F_FRAME) == 0 && !pause) begin
            k_f   <= k_f + 1;
            stp_f <= ((k_f + 1) % F_STEP) == 0;
         end else begin
            stp_f <= 1'b0;
         end
      end
   end

   // Compare both DUTs against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      vt_t got_s, got_f;
      if (chk_en) begin
         got_s = {vif_s.x, vif_s.y, vif_s.de, vif_s.hsync, vif_s.vsync,
                  vif_s.frame_start, vif_s.line_start, vif_s.step};
         got_f = {vif_f.x, vif_f.y, vif_f.de, vif_f.hsync, vif_f.vsync,
                  vif_f.frame_start, vif_f.line_start, vif_f.step};
         check($sformatf("raster_small pos=%0d", pos_s), int'(got_s),
               int'(expect_out(1'b0, pos_s, stp_s)));
         check($sformatf("raster_full pos=%0d", pos_f), int'(got_f),
               int'(expect_out(1'b1, pos_f, stp_f)));
      end
   end

   // Random pause, changed only mid-frame so frame starts see a settled value.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_en && pos_s == S_FRAME / 2) pause = ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      int de_cnt, hs_cnt, ls_cnt, vs_cnt;
      int steps[$];
      vt_t r;
      n_pass = 0; n_total = 0;
      de_cnt = 0; hs_cnt = 0; ls_cnt = 0; vs_cnt = 0;
      chk_en = 1'b0; rand_en = 1'b0;
      pos_s = -1; pos_f = -1; k_s = 0; k_f = 0; stp_s = 1'b0; stp_f = 1'b0;
      rst = 1'b1;
      pause = 1'b0;

      // Hand-computed pins on the model arithmetic (800x525 raster).
      r = raster_sel(1'b1, 655);            check("pin_hs655",  int'(r.hsync), 1);
      r = raster_sel(1'b1, 656);            check("pin_hs656",  int'(r.hsync), 0);
      r = raster_sel(1'b1, 751);            check("pin_hs751",  int'(r.hsync), 0);
      r = raster_sel(1'b1, 752);            check("pin_hs752",  int'(r.hsync), 1);
      r = raster_sel(1'b1, 639);            check("pin_de639",  int'(r.de), 1);
      r = raster_sel(1'b1, 640);            check("pin_de640",  int'(r.de), 0);
      r = raster_sel(1'b1, 479 * 800);      check("pin_de_y479", int'(r.de), 1);
      r = raster_sel(1'b1, 480 * 800);      check("pin_de_y480", int'(r.de), 0);
      r = raster_sel(1'b1, 489 * 800 + 799); check("pin_vs489", int'(r.vsync), 1);
      r = raster_sel(1'b1, 490 * 800);      check("pin_vs490",  int'(r.vsync), 0);
      r = raster_sel(1'b1, 492 * 800 - 1);  check("pin_vs491e", int'(r.vsync), 0);
      r = raster_sel(1'b1, 492 * 800);      check("pin_vs492",  int'(r.vsync), 1);
      r = raster_sel(1'b1, 419999);         check("pin_last_x", int'(r.x), 799);
                                            check("pin_last_y", int'(r.y), 524);
      r = raster_sel(1'b1, 420000);         check("pin_wrap_fs", int'(r.fs), 1);
      r = raster_sel(1'b1, 800);            check("pin_line1_y", int'(r.y), 1);

      // Reset for 5 cycles, then release.
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed window: cycle 0 is the first post-reset pixel.
      for (int i = 0; i <= 1700; i++) begin
         if (i < 800) begin
            if (vif_f.de) de_cnt++;
            if (!vif_f.hsync) hs_cnt++;
         end
         if (i <= 800 && vif_f.line_start) ls_cnt++;
         if (i < S_FRAME && !vif_s.vsync) vs_cnt++;
         if (vif_s.step) steps.push_back(i);
         if (i == 660) pause = 1'b1;   // spans the frame start at cycle 792
         if (i == 924) pause = 1'b0;
         @(posedge clk);
         #1;
      end
      check("line_de_cycles", de_cnt, 640);
      check("line_hsync_low", hs_cnt, 96);
      check("line_start_pulses", ls_cnt, 2);
      check("small_vsync_low", vs_cnt, 48);
      check("step_count", steps.size(), 2);
      check("first_step_cycle", (steps.size() > 0) ? steps[0] : -1, 528);
      check("paused_step_cycle", (steps.size() > 1) ? steps[1] : -1, 1584);

      // Random run with mid-frame resets and random pause.
      rand_en = 1'b1;
      for (int it = 0; it < 16; it++) begin
         repeat ($urandom_range(100, 3000)) @(posedge clk);
         #1;
         rst = 1'b1;
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
         rst = 1'b0;
      end
      repeat (600) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
